// File: rtl/b_ch_resp_pkg.sv
// b_ch_resp_pkg: AXI widths, response codes and B-return source indices.
package b_ch_resp_pkg;
   localparam int AXI_ID_BITS = 4;
   localparam int AXI_IDS_BITS = 8;
   localparam int AXI_RESP_BITS = 2;
   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
   typedef enum logic [1:0] {SRC_S0, SRC_S1, SRC_S2, SRC_DEC} src_e;
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-request round-robin arbiter; scan starts at i_ptr and wraps.
module rr_arb4 (
   input  logic [3:0] i_req,
   input  logic [1:0] i_ptr,
   output logic [3:0] o_gnt,
   output logic [1:0] o_gnt_idx
);
   logic       w_found;
   logic [1:0] w_idx;
   always_comb begin
      w_found = 1'b0;
      w_idx = i_ptr;
      o_gnt_idx = i_ptr;
      for (int i = 0; i < 4; i++) begin
         w_idx = i_ptr + i[1:0];
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            o_gnt_idx = w_idx;
         end
      end
      o_gnt = w_found ? 4'b0001 << o_gnt_idx : 4'b0000;
   end
endmodule

// File: rtl/b_ch_resp.sv
// b_ch_resp: B-channel return path; round-robin over S0..S2 and a DECERR slot
// into a one-entry registered output stage toward M1.
module b_ch_resp
   import b_ch_resp_pkg::*;
#(
   parameter int ID_W   = AXI_ID_BITS,
   parameter int IDS_W  = AXI_IDS_BITS,
   parameter int RESP_W = AXI_RESP_BITS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [IDS_W-1:0]  bid_s0_i,
   input  logic [IDS_W-1:0]  bid_s1_i,
   input  logic [IDS_W-1:0]  bid_s2_i,
   input  logic [RESP_W-1:0] bresp_s0_i,
   input  logic [RESP_W-1:0] bresp_s1_i,
   input  logic [RESP_W-1:0] bresp_s2_i,
   input  logic              bvalid_s0_i,
   input  logic              bvalid_s1_i,
   input  logic              bvalid_s2_i,
   output logic              bready_s0_o,
   output logic              bready_s1_o,
   output logic              bready_s2_o,
   input  logic              decerr_req_i,
   input  logic [IDS_W-1:0]  decerr_id_i,
   output logic [ID_W-1:0]   bid_m1_o,
   output logic [RESP_W-1:0] bresp_m1_o,
   output logic              bvalid_m1_o,
   input  logic              bready_m1_i,
   output logic              decerr_ovf_o
);
   logic              r_bvalid, r_dec_pend, r_ovf;
   logic [ID_W-1:0]   r_id, r_dec_id;
   logic [RESP_W-1:0] r_resp;
   logic [1:0]        r_ptr, w_idx;
   logic [3:0]        w_gnt;
   logic              w_load_en;
   src_e              w_src;
   logic [ID_W-1:0]   w_id;
   logic [RESP_W-1:0] w_resp;
   logic              w_unused_ids;
   // Gating with rst keeps every slave un-readied while reset is held.
   assign w_load_en = rst & (!r_bvalid | bready_m1_i);
   rr_arb4 u_arb (
      .i_req    ({r_dec_pend, bvalid_s2_i, bvalid_s1_i, bvalid_s0_i} & {4{w_load_en}}),
      .i_ptr    (r_ptr),
      .o_gnt    (w_gnt),
      .o_gnt_idx(w_idx)
   );
   assign w_src = src_e'(w_idx);
   assign w_id = w_src == SRC_S0 ? bid_s0_i[ID_W-1:0] :
                 w_src == SRC_S1 ? bid_s1_i[ID_W-1:0] :
                 w_src == SRC_S2 ? bid_s2_i[ID_W-1:0] : r_dec_id;
   assign w_resp = w_src == SRC_S0 ? bresp_s0_i :
                   w_src == SRC_S1 ? bresp_s1_i :
                   w_src == SRC_S2 ? bresp_s2_i : RESP_W'(AXI_RESP_DECERR);
   // Upper slave-ID bits carry the master index and are dropped on the M1 side.
   assign w_unused_ids = ^{bid_s0_i[IDS_W-1:ID_W], bid_s1_i[IDS_W-1:ID_W],
                           bid_s2_i[IDS_W-1:ID_W], decerr_id_i[IDS_W-1:ID_W]};
   assign bready_s0_o = w_gnt[0];
   assign bready_s1_o = w_gnt[1];
   assign bready_s2_o = w_gnt[2];
   assign bid_m1_o = r_id;
   assign bresp_m1_o = r_resp;
   assign bvalid_m1_o = r_bvalid;
   assign decerr_ovf_o = r_ovf;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bvalid <= 1'b0;
         r_id <= '0;
         r_resp <= RESP_W'(AXI_RESP_OKAY);
         r_ptr <= 2'd0;
         r_dec_pend <= 1'b0;
         r_dec_id <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (|w_gnt) begin
            r_bvalid <= 1'b1;
            r_id <= w_id;
            r_resp <= w_resp;
            r_ptr <= w_idx + 2'd1;
         end else if (bready_m1_i) begin
            r_bvalid <= 1'b0;
         end
         // A new request may refill the slot in the same cycle it is drained.
         if (decerr_req_i && (!r_dec_pend || w_gnt[3])) begin
            r_dec_pend <= 1'b1;
            r_dec_id <= decerr_id_i[ID_W-1:0];
         end else if (decerr_req_i) begin
            r_ovf <= 1'b1;
         end else if (w_gnt[3]) begin
            r_dec_pend <= 1'b0;
         end
      end
   end
endmodule
